sysid_regs: RTL and testbench

SYSID_REGS -- requirements
Module: sysid_regs

---
 rtl/sysid_regs_pkg.sv | 27 ++
 rtl/sysid_uptime_counter.sv | 27 ++
 rtl/sysid_regs.sv | 99 +++++++++
 tb/tb_sysid_regs.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sysid_regs_pkg.sv
// rtl/sysid_regs_pkg.sv - shared register map, control bit positions and counter width
package sysid_regs_pkg;

   localparam int CNT_W = 64;

   localparam logic [3:0] ADDR_ID         = 4'd0;
   localparam logic [3:0] ADDR_TIMESTAMP  = 4'd1;
   localparam logic [3:0] ADDR_UPTIME_LO  = 4'd2;
   localparam logic [3:0] ADDR_UPTIME_HI  = 4'd3;
   localparam logic [3:0] ADDR_CONTROL    = 4'd4;
   localparam logic [3:0] ADDR_SCRATCH0   = 4'd5;

   localparam int CTRL_CLEAR_BIT  = 0;
   localparam int CTRL_FREEZE_BIT = 1;

   function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// rtl/sysid_uptime_counter.sv - free-running 64-bit uptime counter with clear and freeze
module sysid_uptime_counter
   import sysid_regs_pkg::*;
(
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_freeze,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // clear wins over freeze and increment; wraps naturally at 2^64-1
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (!i_freeze) begin
         r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/sysid_regs.sv
// rtl/sysid_regs.sv - Avalon-MM system ID / uptime / scratch register block
module sysid_regs
   import sysid_regs_pkg::*;
#(
   parameter logic [31:0] ID_VALUE    = 32'h5B6F883F,
   parameter logic [31:0] TIMESTAMP   = 32'h0,
   parameter int          NUM_SCRATCH = 4
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   logic [CNT_W-1:0] w_count;
   logic             w_ctrl_we;
   logic             w_clear;
   logic             w_lo_read;
   logic [31:0]      w_rdata;
   logic [31:0]      w_scratch_rd;

   logic             r_freeze;
   logic [31:0]      r_snap_hi;
   logic [31:0]      r_readdata;
   logic             r_readdatavalid;
   logic [31:0]      r_scratch [NUM_SCRATCH];

   assign w_ctrl_we = write && (address == ADDR_CONTROL) && byteenable[0];
   assign w_clear   = w_ctrl_we && writedata[CTRL_CLEAR_BIT];
   assign w_lo_read = read && (address == ADDR_UPTIME_LO);

   sysid_uptime_counter u_uptime (
      .i_clock  (clock),
      .i_reset  (reset),
      .i_clear  (w_clear),
      .i_freeze (r_freeze),
      .o_count  (w_count)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_freeze <= 1'b0;
      end else if (w_ctrl_we) begin
         r_freeze <= writedata[CTRL_FREEZE_BIT];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= '0;
      end else if (write) begin
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (address == 4'(int'(ADDR_SCRATCH0) + i))
               r_scratch[i] <= apply_be(r_scratch[i], writedata, byteenable);
         end
      end
   end

   always_comb begin
      w_scratch_rd = '0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
         if (address == 4'(int'(ADDR_SCRATCH0) + i)) w_scratch_rd = r_scratch[i];
      end
   end

   // mux sees pre-write state, so a simultaneous read returns the old value
   always_comb begin
      w_rdata = '0;
      case (address)
         ADDR_ID:        w_rdata = ID_VALUE;
         ADDR_TIMESTAMP: w_rdata = TIMESTAMP;
         ADDR_UPTIME_LO: w_rdata = w_count[31:0];
         ADDR_UPTIME_HI: w_rdata = r_snap_hi;
         ADDR_CONTROL:   w_rdata[CTRL_FREEZE_BIT] = r_freeze;
         default:        w_rdata = w_scratch_rd;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_readdata      <= '0;
         r_readdatavalid <= 1'b0;
         r_snap_hi       <= '0;
      end else begin
         r_readdatavalid <= read;
         if (read) r_readdata <= w_rdata;
         if (w_lo_read) r_snap_hi <= w_count[63:32];
      end
   end

   assign readdata      = r_readdata;
   assign readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_sysid_regs.sv
// tb/tb_sysid_regs.sv - directed self-checking bench for sysid_regs
module tb_sysid_regs;

   logic        clock;
   logic        reset;
   logic [3:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;
   logic        readdatavalid;

   int total = 0;
   int bad   = 0;

   logic [31:0] d;
   logic [31:0] d2;
   logic        v;

   sysid_regs dut (
      .clock         (clock),
      .reset         (reset),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .readdata      (readdata),
      .readdatavalid (readdatavalid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
      @(negedge clock);
      address = a; writedata = wd; byteenable = be; write = 1'b1; read = 1'b0;
      @(negedge clock);
      write = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] a, output logic [31:0] rd, output logic rv);
      @(negedge clock);
      address = a; read = 1'b1; write = 1'b0;
      @(negedge clock);
      rd = readdata; rv = readdatavalid;
      read = 1'b0;
   endtask

   initial begin
      reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
      writedata = '0; byteenable = '0;
      repeat (3) @(negedge clock);
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_valid", {31'b0, readdatavalid}, 32'h0);
      chk("rst_snap", dut.r_snap_hi, 32'h0);
      reset = 1'b0;

      // back-to-back ID / TIMESTAMP reads with exact 1-cycle latency
      @(negedge clock);
      chk("idle_valid", {31'b0, readdatavalid}, 32'h0);
      address = 4'd0; read = 1'b1;
      @(negedge clock);
      chk("id_valid", {31'b0, readdatavalid}, 32'h1);
      chk("id_data", readdata, 32'h5B6F883F);
      address = 4'd1;
      @(negedge clock);
      chk("ts_valid", {31'b0, readdatavalid}, 32'h1);
      chk("ts_data", readdata, 32'h00000000);
      read = 1'b0;
      @(negedge clock);
      chk("after_valid", {31'b0, readdatavalid}, 32'h0);

      // byte-enabled scratch write, hold, unmapped addresses
      do_write(4'd5, 32'hA5A5A5A5, 4'b0101);
      do_read(4'd5, d, v);
      chk("scr5_valid", {31'b0, v}, 32'h1);
      chk("scr5_data", d, 32'h00A500A5);
      @(negedge clock);
      chk("hold_valid", {31'b0, readdatavalid}, 32'h0);
      chk("hold_data", readdata, 32'h00A500A5);
      do_read(4'd15, d, v);
      chk("addr15", d, 32'h0);
      do_write(4'd8, 32'hCAFEF00D, 4'hF);
      do_read(4'd8, d, v);
      chk("scr_last", d, 32'hCAFEF00D);
      do_write(4'd9, 32'hFFFFFFFF, 4'hF);
      do_read(4'd9, d, v);
      chk("addr9_unmapped", d, 32'h0);

      // tear-free LO/HI read across a 32-bit carry
      @(negedge clock);
      force dut.u_uptime.r_count = 64'h00000000_FFFFFFFF;
      address = 4'd2; read = 1'b1;
      @(negedge clock);
      release dut.u_uptime.r_count;
      read = 1'b0;
      chk("lo_carry", readdata, 32'hFFFFFFFF);
      @(negedge clock);
      do_read(4'd3, d, v);
      chk("hi_snap", d, 32'h00000000);

      // freeze then clear
      do_write(4'd4, 32'h00000002, 4'hF);
      do_read(4'd4, d, v);
      chk("ctrl_freeze_rd", d, 32'h00000002);
      repeat (10) @(negedge clock);
      do_read(4'd2, d, v);
      do_read(4'd2, d2, v);
      chk("frozen_equal", d2, d);
      do_write(4'd4, 32'h00000001, 4'hF);
      do_read(4'd4, d, v);
      chk("ctrl_clear_rd0", d, 32'h00000000);
      do_write(4'd4, 32'h00000001, 4'hF);
      do_read(4'd2, d, v);
      chk("cleared_small", {31'b0, (d < 32'd3)}, 32'h1);

      // simultaneous read+write returns pre-write value
      do_write(4'd6, 32'h11111111, 4'hF);
      @(negedge clock);
      address = 4'd6; writedata = 32'h22222222; byteenable = 4'hF;
      read = 1'b1; write = 1'b1;
      @(negedge clock);
      read = 1'b0; write = 1'b0;
      chk("rw_old", readdata, 32'h11111111);
      do_read(4'd6, d, v);
      chk("rw_new", d, 32'h22222222);

      // nonzero snapshot, then reset during a pending read
      @(negedge clock);
      force dut.u_uptime.r_count = 64'h00000007_00000000;
      address = 4'd2; read = 1'b1;
      @(negedge clock);
      release dut.u_uptime.r_count;
      read = 1'b0;
      chk("lo_zero", readdata, 32'h00000000);
      do_read(4'd3, d, v);
      chk("hi_seven", d, 32'h00000007);
      @(negedge clock);
      address = 4'd2; read = 1'b1;
      #3 reset = 1'b1;
      @(negedge clock);
      chk("rst_rd_valid", {31'b0, readdatavalid}, 32'h0);
      chk("rst_rd_data", readdata, 32'h0);
      chk("rst_rd_snap", dut.r_snap_hi, 32'h0);

      // first increment lands on the first edge after reset release
      reset = 1'b0;
      @(negedge clock);
      chk("post_rst_valid", {31'b0, readdatavalid}, 32'h1);
      chk("post_rst_lo0", readdata, 32'h0);
      @(negedge clock);
      chk("post_rst_lo1", readdata, 32'h1);
      read = 1'b0;
      @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
